// File: rtl/multdiv_sequencer.sv
// Iterative signed 32x32 multiply / divide for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle over 32 cycles.
module multdiv_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dx_ir_in,
    input  logic [31:0] dx_operand_a,
    input  logic [31:0] dx_operand_b,
    input  logic        dx_load,
    output logic        multdiv_is_running,
    output logic        multdiv_result_ready,
    output logic [31:0] multdiv_result,
    output logic        multdiv_exception,
    output logic [4:0]  multdiv_rd
);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StWait} state_e;

    state_e      r_state, w_state_nxt;
    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic        r_op_div;
    logic        r_neg;
    logic        r_div_zero;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_exc;
    logic [4:0]  r_rd;

    logic        w_is_mul, w_is_div, w_launch, w_last;
    logic [31:0] w_mag_a, w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_fin_result;
    logic        w_fin_exc;
    logic        w_unused_ir;

    assign w_is_mul    = (dx_ir_in[31:27] == 5'b00000) && (dx_ir_in[6:2] == 5'b00110);
    assign w_is_div    = (dx_ir_in[31:27] == 5'b00000) && (dx_ir_in[6:2] == 5'b00111);
    assign w_launch    = (r_state == StIdle) && (w_is_mul || w_is_div);
    assign w_last      = (r_state == StRun) && (r_cnt == 5'd31);
    assign w_unused_ir = ^{dx_ir_in[21:7], dx_ir_in[1:0]};

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign w_mag_a = dx_operand_a[31] ? (~dx_operand_a + 32'd1) : dx_operand_a;
    assign w_mag_b = dx_operand_b[31] ? (~dx_operand_b + 32'd1) : dx_operand_b;

    // Multiply: upper half accumulates, whole register shifts right; multiplier sits in the low half.
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at bit 0.
    assign w_div_shift = {r_acc[62:0], 1'b0};
    assign w_div_diff  = {1'b0, w_div_shift[63:32]} - {1'b0, r_opb};

    always_comb begin
        w_acc_nxt = 64'd0;
        if (r_op_div) begin
            if (!w_div_diff[32]) begin
                w_acc_nxt = {w_div_diff[31:0], w_div_shift[31:1], 1'b1};
            end else begin
                w_acc_nxt = w_div_shift;
            end
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[31:1]};
        end
    end

    assign w_prod = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
    assign w_quot = r_neg ? (~w_acc_nxt[31:0] + 32'd1) : w_acc_nxt[31:0];

    always_comb begin
        w_fin_result = 32'd0;
        w_fin_exc    = 1'b0;
        if (r_op_div) begin
            if (r_div_zero) begin
                w_fin_exc = 1'b1;
            end else begin
                w_fin_result = w_quot;
                // Only a positive quotient of 2^31 can overflow.
                w_fin_exc    = !r_neg && w_acc_nxt[31];
            end
        end else begin
            w_fin_result = w_prod[31:0];
            w_fin_exc    = !((&w_prod[63:31]) || (~|w_prod[63:31]));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        multdiv_is_running   = 1'b0;
        multdiv_result_ready = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_launch) w_state_nxt = StRun;
            end
            StRun: begin
                multdiv_is_running = 1'b1;
                if (w_last) w_state_nxt = StDone;
            end
            StDone: begin
                multdiv_result_ready = 1'b1;
                w_state_nxt          = dx_load ? StIdle : StWait;
            end
            StWait: begin
                if (dx_load) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= 64'd0;
            r_opb      <= 32'd0;
            r_op_div   <= 1'b0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= 5'd0;
            r_result   <= 32'd0;
            r_exc      <= 1'b0;
            r_rd       <= 5'd0;
        end else if (w_launch) begin
            r_op_div   <= w_is_div;
            r_neg      <= dx_operand_a[31] ^ dx_operand_b[31];
            r_div_zero <= (dx_operand_b == 32'd0);
            r_cnt      <= 5'd0;
            r_rd       <= dx_ir_in[26:22];
            r_opb      <= w_is_div ? w_mag_b : w_mag_a;
            r_acc      <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
        end else if (r_state == StRun) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_result <= w_fin_result;
                r_exc    <= w_fin_exc;
            end
        end
    end

    assign multdiv_result    = r_result;
    assign multdiv_exception = r_exc;
    assign multdiv_rd        = r_rd;

endmodule
